// File: rtl/system_qsys_nios2_div_cell.sv
// Iterative radix-2 restoring divider (signed/unsigned) with start/done handshake.
// Fixed latency: a start accepted in cycle N gives a done pulse in cycle N+DATA_WIDTH+3.
module system_qsys_nios2_div_cell #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] A_div_src1,
   input  logic [DATA_WIDTH-1:0] A_div_src2,
   input  logic                  A_div_signed,
   input  logic                  A_div_start,
   output logic                  A_div_busy,
   output logic                  A_div_done,
   output logic [DATA_WIDTH-1:0] A_div_quotient,
   output logic [DATA_WIDTH-1:0] A_div_remainder
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PREP = 2'd1;
   localparam logic [1:0] ITER = 2'd2;
   localparam logic [1:0] FIX  = 2'd3;

   logic [1:0]    r_state;
   logic [W-1:0]  r_src1;
   logic [W-1:0]  r_src2;
   logic          r_signed;
   logic [W-1:0]  r_dvd;    // dividend magnitude, shifts out MSB-first while quotient bits shift in
   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_dvs;
   logic [CW-1:0] r_cnt;
   logic          r_qneg;
   logic          r_rneg;
   logic          r_dz;
   logic          r_done;
   logic [W-1:0]  r_quot;
   logic [W-1:0]  r_remo;

   logic          w_sa;
   logic          w_sb;
   logic [W:0]    w_shift;
   logic          w_ge;
   logic [W-1:0]  w_diff;

   assign w_sa    = r_signed & r_src1[W-1];
   assign w_sb    = r_signed & r_src2[W-1];
   // The W+1-bit compare is the sign test of the trial subtraction; when the trial
   // is kept the difference always fits in W bits, so the subtract itself can stay narrow.
   assign w_shift = {r_rem, r_dvd[W-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_diff  = w_shift[W-1:0] - r_dvs;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_src1   <= '0;
         r_src2   <= '0;
         r_signed <= 1'b0;
         r_dvd    <= '0;
         r_rem    <= '0;
         r_dvs    <= '0;
         r_cnt    <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_dz     <= 1'b0;
         r_done   <= 1'b0;
         r_quot   <= '0;
         r_remo   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (A_div_start) begin
                  r_src1   <= A_div_src1;
                  r_src2   <= A_div_src2;
                  r_signed <= A_div_signed;
                  r_state  <= PREP;
               end
            end
            PREP: begin
               r_dvd   <= w_sa ? -r_src1 : r_src1;
               r_dvs   <= w_sb ? -r_src2 : r_src2;
               r_qneg  <= w_sa ^ w_sb;
               r_rneg  <= w_sa;
               r_dz    <= (r_src2 == '0);
               r_rem   <= '0;
               r_cnt   <= CW'(W - 1);
               r_state <= ITER;
            end
            ITER: begin
               r_rem <= w_ge ? w_diff : w_shift[W-1:0];
               r_dvd <= {r_dvd[W-2:0], w_ge};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state <= FIX;
               end
            end
            default: begin
               if (r_dz) begin
                  r_quot <= '1;
                  r_remo <= r_src1;
               end else begin
                  r_quot <= r_qneg ? -r_dvd : r_dvd;
                  r_remo <= r_rneg ? -r_rem : r_rem;
               end
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign A_div_busy      = (r_state != IDLE);
   assign A_div_done      = r_done;
   assign A_div_quotient  = r_quot;
   assign A_div_remainder = r_remo;

endmodule

// File: tb/tb_system_qsys_nios2_div_cell.sv
// Directed vector bench for system_qsys_nios2_div_cell: table of divisions plus
// hand-written sequences for busy-start, back-to-back and mid-operation reset.
module tb_system_qsys_nios2_div_cell;

   logic        clk;
   logic        reset;
   logic [31:0] A_div_src1;
   logic [31:0] A_div_src2;
   logic        A_div_signed;
   logic        A_div_start;
   logic        A_div_busy;
   logic        A_div_done;
   logic [31:0] A_div_quotient;
   logic [31:0] A_div_remainder;

   int n_checks = 0;
   int n_errors = 0;

   system_qsys_nios2_div_cell #(.DATA_WIDTH(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .A_div_src1      (A_div_src1),
      .A_div_src2      (A_div_src2),
      .A_div_signed    (A_div_signed),
      .A_div_start     (A_div_start),
      .A_div_busy      (A_div_busy),
      .A_div_done      (A_div_done),
      .A_div_quotient  (A_div_quotient),
      .A_div_remainder (A_div_remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] src1;
      logic [31:0] src2;
      logic        sgn;
      logic [31:0] exp_q;
      logic [31:0] exp_r;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge (cycle N+1).
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      A_div_src1   = a;
      A_div_src2   = b;
      A_div_signed = s;
      A_div_start  = 1'b1;
      @(negedge clk);
      A_div_start  = 1'b0;
      A_div_src1   = $urandom;
      A_div_src2   = $urandom;
      A_div_signed = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!A_div_done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int dones;

      vecs[0]  = '{32'd100,      32'd7,          1'b0, 32'd14,       32'd2};
      vecs[1]  = '{-32'sd100,    32'd7,          1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE};
      vecs[2]  = '{32'd100,      -32'sd7,        1'b1, 32'hFFFFFFF2, 32'd2};
      vecs[3]  = '{-32'sd100,    -32'sd7,        1'b1, 32'd14,       32'hFFFFFFFE};
      vecs[4]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0};
      vecs[5]  = '{32'hFFFFFFFF, 32'd1,          1'b0, 32'hFFFFFFFF, 32'd0};
      vecs[6]  = '{32'h12345678, 32'd0,          1'b0, 32'hFFFFFFFF, 32'h12345678};
      vecs[7]  = '{32'h12345678, 32'd0,          1'b1, 32'hFFFFFFFF, 32'h12345678};
      vecs[8]  = '{32'h80000000, 32'hFFFFFFFF,   1'b0, 32'd0,        32'h80000000};
      vecs[9]  = '{32'd9,        32'd3,          1'b0, 32'd3,        32'd0};
      vecs[10] = '{32'd7,        32'd100,        1'b0, 32'd0,        32'd7};
      vecs[11] = '{32'h80000000, 32'd2,          1'b1, 32'hC0000000, 32'd0};
      vecs[12] = '{32'hFFFFFFFF, 32'hFFFFFFFF,   1'b1, 32'd1,        32'd0};
      vecs[13] = '{32'hFFFFFFFF, 32'h00010000,   1'b0, 32'h0000FFFF, 32'h0000FFFF};

      reset        = 1'b1;
      A_div_src1   = '0;
      A_div_src2   = '0;
      A_div_signed = 1'b0;
      A_div_start  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_busy", 32'(A_div_busy), 32'd0);
      chk("reset_done", 32'(A_div_done), 32'd0);
      chk("reset_quot", A_div_quotient, 32'd0);
      chk("reset_rem",  A_div_remainder, 32'd0);

      foreach (vecs[i]) begin
         issue(vecs[i].src1, vecs[i].src2, vecs[i].sgn);
         chk($sformatf("v%0d_busy_early", i), 32'(A_div_busy), 32'd1);
         wait_done(cyc);
         chk($sformatf("v%0d_latency", i), 32'(cyc), 32'd35);
         chk($sformatf("v%0d_quot", i), A_div_quotient, vecs[i].exp_q);
         chk($sformatf("v%0d_rem", i), A_div_remainder, vecs[i].exp_r);
         chk($sformatf("v%0d_busy_done", i), 32'(A_div_busy), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), 32'(A_div_done), 32'd0);
         chk($sformatf("v%0d_hold_q", i), A_div_quotient, vecs[i].exp_q);
      end

      // Start pulses while busy must be ignored.
      issue(32'd100, 32'd7, 1'b0);
      cyc = 1;
      while (!A_div_done && cyc < 100) begin
         if (cyc == 5 || cyc == 20) begin
            A_div_src1  = 32'd9;
            A_div_src2  = 32'd3;
            A_div_start = 1'b1;
         end else begin
            A_div_start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      A_div_start = 1'b0;
      chk("ign_latency", 32'(cyc), 32'd35);
      chk("ign_quot", A_div_quotient, 32'd14);
      chk("ign_rem",  A_div_remainder, 32'd2);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (A_div_done) dones++;
      end
      chk("ign_no_extra_done", 32'(dones), 32'd0);
      chk("ign_idle", 32'(A_div_busy), 32'd0);

      // Back-to-back: new start in the done cycle.
      issue(32'd1000, 32'd10, 1'b0);
      wait_done(cyc);
      chk("b2b_first_quot", A_div_quotient, 32'd100);
      issue(32'd9, 32'd3, 1'b0);
      chk("b2b_busy", 32'(A_div_busy), 32'd1);
      chk("b2b_hold_quot", A_div_quotient, 32'd100);
      chk("b2b_hold_rem",  A_div_remainder, 32'd0);
      wait_done(cyc);
      chk("b2b_latency", 32'(cyc), 32'd35);
      chk("b2b_quot", A_div_quotient, 32'd3);
      chk("b2b_rem",  A_div_remainder, 32'd0);

      // Reset in the middle of a division.
      @(negedge clk);
      issue(32'd100, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", 32'(A_div_busy), 32'd0);
      chk("rst_done", 32'(A_div_done), 32'd0);
      chk("rst_quot", A_div_quotient, 32'd0);
      chk("rst_rem",  A_div_remainder, 32'd0);
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (A_div_done) dones++;
      end
      chk("rst_no_done", 32'(dones), 32'd0);
      issue(32'd9, 32'd3, 1'b0);
      wait_done(cyc);
      chk("rst_fresh_latency", 32'(cyc), 32'd35);
      chk("rst_fresh_quot", A_div_quotient, 32'd3);
      chk("rst_fresh_rem",  A_div_remainder, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
